// File: rtl/cpu_pkg.sv
// Shared CPU control definitions for the PC controller slice.
// Holds the PC source-mux codes, exception cause codes, the exception
// vector base address, the exception FSM state encoding and the grant
// bit positions used by the request arbiter.
package cpu_pkg;

  // Select codes for the 8-input PC source mux; 6 and 7 are never driven.
  typedef enum logic [2:0] {
    PC_SRC_SEQ = 3'd0,
    PC_SRC_BR  = 3'd1,
    PC_SRC_JMP = 3'd2,
    PC_SRC_RS  = 3'd3,
    PC_SRC_VEC = 3'd4,
    PC_SRC_EPC = 3'd5
  } pc_src_e;

  typedef enum logic [1:0] {
    CAUSE_INV_OP = 2'd0,
    CAUSE_OVF    = 2'd1,
    CAUSE_DIV0   = 2'd2,
    CAUSE_RSVD   = 2'd3
  } exc_cause_e;

  localparam logic [7:0] EXC_VEC_BASE = 8'd253;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXC_EPC = 2'd1,
    ST_EXC_RD  = 2'd2,
    ST_EXC_LD  = 2'd3
  } pc_state_e;

  // One-hot grant vector bit positions.
  localparam int GNT_W   = 6;
  localparam int GNT_SEQ = 0;
  localparam int GNT_BR  = 1;
  localparam int GNT_JMP = 2;
  localparam int GNT_RS  = 3;
  localparam int GNT_EPC = 4;
  localparam int GNT_EXC = 5;

  // Vector byte address for a cause; the reserved cause aliases the base
  // so the address never wraps past 255.
  function automatic logic [7:0] exc_vec_addr(input logic [1:0] cause);
    return (cause == CAUSE_RSVD) ? EXC_VEC_BASE : EXC_VEC_BASE + {6'd0, cause};
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Request/response bundle between the decode stage and the PC controller.
// master: requester side (drives requests, receives PC/EPC/memory controls).
// slave : pc_ctrl side.
interface pc_ctrl_if;
  logic       seq_req;
  logic       br_req;
  logic       br_cond;
  logic       j_req;
  logic       jr_req;
  logic       rte_req;
  logic       exc_req;
  logic [1:0] exc_cause;
  logic [2:0] pc_src;
  logic       pc_write;
  logic       epc_write;
  logic       exc_mem_rd;
  logic [7:0] exc_addr;
  logic       busy;

  modport master (
    output seq_req, br_req, br_cond, j_req, jr_req, rte_req, exc_req, exc_cause,
    input  pc_src, pc_write, epc_write, exc_mem_rd, exc_addr, busy
  );

  modport slave (
    input  seq_req, br_req, br_cond, j_req, jr_req, rte_req, exc_req, exc_cause,
    output pc_src, pc_write, epc_write, exc_mem_rd, exc_addr, busy
  );
endinterface

// File: rtl/pc_req_arb.sv
// Fixed-priority PC request resolver (combinational).
// Priority: exc > rte > jr > j > branch-taken > seq.
// Inputs : individual request lines, br_cond qualifying br_req.
// Outputs: gnt, one-hot (or all zero when nothing is requested).
module pc_req_arb import cpu_pkg::*; (
  input  logic             exc_req,
  input  logic             rte_req,
  input  logic             jr_req,
  input  logic             j_req,
  input  logic             br_req,
  input  logic             br_cond,
  input  logic             seq_req,
  output logic [GNT_W-1:0] gnt
);
  // A not-taken branch simply drops out; if seq_req is also up it wins
  // on its own, which gives the fall-through behaviour.
  always_comb begin
    gnt = '0;
    if (exc_req)                gnt[GNT_EXC] = 1'b1;
    else if (rte_req)           gnt[GNT_EPC] = 1'b1;
    else if (jr_req)            gnt[GNT_RS]  = 1'b1;
    else if (j_req)             gnt[GNT_JMP] = 1'b1;
    else if (br_req && br_cond) gnt[GNT_BR]  = 1'b1;
    else if (seq_req)           gnt[GNT_SEQ] = 1'b1;
  end
endmodule

// File: rtl/pc_ctrl.sv
// PC controller: arbitrates PC update requests and sequences exception
// entry (save EPC, fetch vector from memory, load PC).
// Optional feature macro: PC_CTRL_EXC_EN enables the exception sequence;
// without it exc_req is ignored and the exception outputs are tied to 0.
// Ports: clk, reset_n (async, active low), bus (pc_ctrl_if.slave) carrying
// the request lines and pc_src/pc_write/epc_write/exc_mem_rd/exc_addr/busy.
// MEM_LAT: vector fetch latency in cycles, legal 1..7.
module pc_ctrl import cpu_pkg::*; #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  pc_ctrl_if.slave   bus
);
`ifdef PC_CTRL_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  pc_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       pc_src_q, pc_src_d;
  logic             pc_write_q, pc_write_d;
  logic [7:0]       exc_addr_q, exc_addr_d;
  logic [GNT_W-1:0] gnt;

  pc_req_arb u_arb (
    .exc_req (EXC_EN && bus.exc_req),
    .rte_req (bus.rte_req),
    .jr_req  (bus.jr_req),
    .j_req   (bus.j_req),
    .br_req  (bus.br_req),
    .br_cond (bus.br_cond),
    .seq_req (bus.seq_req),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pc_src_q   <= PC_SRC_SEQ;
      pc_write_q <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_src_q   <= pc_src_d;
      pc_write_q <= pc_write_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  // Next state; the counter is loaded on EXC_EPC entry and only
  // decrements while nonzero, leaving EXC_RD on its last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (gnt[GNT_EXC]) begin
        state_d = ST_EXC_EPC;
        cnt_d   = LAT;
      end
      ST_EXC_EPC: state_d = ST_EXC_RD;
      ST_EXC_RD: begin
        if (cnt_q <= 3'd1) state_d = ST_EXC_LD;
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      end
      ST_EXC_LD: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: requests only win in IDLE, so anything arriving
  // while busy is dropped. pc_src holds its last value when idle.
  always_comb begin
    pc_src_d   = pc_src_q;
    pc_write_d = 1'b0;
    exc_addr_d = exc_addr_q;
    if (state_q == ST_IDLE) begin
      if (gnt[GNT_EXC]) begin
        exc_addr_d = exc_vec_addr(bus.exc_cause);
      end else if (|gnt) begin
        pc_write_d = 1'b1;
        if (gnt[GNT_EPC])      pc_src_d = PC_SRC_EPC;
        else if (gnt[GNT_RS])  pc_src_d = PC_SRC_RS;
        else if (gnt[GNT_JMP]) pc_src_d = PC_SRC_JMP;
        else if (gnt[GNT_BR])  pc_src_d = PC_SRC_BR;
        else                   pc_src_d = PC_SRC_SEQ;
      end
    end else if (state_q == ST_EXC_RD && state_d == ST_EXC_LD) begin
      pc_src_d   = PC_SRC_VEC;
      pc_write_d = 1'b1;
    end
  end

  assign bus.pc_src     = pc_src_q;
  assign bus.pc_write   = pc_write_q;
  assign bus.epc_write  = EXC_EN && (state_q == ST_EXC_EPC);
  assign bus.exc_mem_rd = EXC_EN && (state_q == ST_EXC_RD);
  assign bus.busy       = EXC_EN && (state_q != ST_IDLE);
  assign bus.exc_addr   = EXC_EN ? exc_addr_q : 8'd0;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed steps followed by random
// traffic, compared every cycle against a frame-schedule reference model.
module tb_pc_ctrl;
  localparam int MEM_LAT = 2;
`ifdef PC_CTRL_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_ctrl_if bus();

  pc_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Expected output values for one clock cycle.
  typedef struct packed {
    logic [2:0] src;
    logic       pw;
    logic       ew;
    logic       mr;
    logic       bz;
    logic [7:0] addr;
  } frame_t;

  frame_t q[$];
  frame_t exp_f;
  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".pc_src"},     8'(bus.pc_src),     8'(exp_f.src));
    check({where, ".pc_write"},   8'(bus.pc_write),   8'(exp_f.pw));
    check({where, ".epc_write"},  8'(bus.epc_write),  8'(exp_f.ew));
    check({where, ".exc_mem_rd"}, 8'(bus.exc_mem_rd), 8'(exp_f.mr));
    check({where, ".exc_addr"},   bus.exc_addr,       exp_f.addr);
    check({where, ".busy"},       8'(bus.busy),       8'(exp_f.bz));
  endtask

  // Reference: an accepted exception schedules its whole output sequence
  // up front; while frames are pending the block is busy and ignores input.
  task automatic model(input logic s, b, c, jj, jr, r, e, input logic [1:0] cause);
    frame_t nf, f;
    nf    = exp_f;
    nf.pw = 1'b0; nf.ew = 1'b0; nf.mr = 1'b0; nf.bz = 1'b0;
    if (q.size() > 0) begin
      nf = q.pop_front();
    end else if (!exp_f.bz) begin
      if (EXC_EN && e) begin
        nf.addr = (cause == 2'd3) ? 8'd253 : 8'd253 + 8'(cause);
        nf.ew   = 1'b1;
        nf.bz   = 1'b1;
        f = nf; f.ew = 1'b0; f.mr = 1'b1;
        for (int i = 0; i < MEM_LAT; i++) q.push_back(f);
        f.mr = 1'b0; f.src = 3'd4; f.pw = 1'b1;
        q.push_back(f);
      end
      else if (r)      begin nf.src = 3'd5; nf.pw = 1'b1; end
      else if (jr)     begin nf.src = 3'd3; nf.pw = 1'b1; end
      else if (jj)     begin nf.src = 3'd2; nf.pw = 1'b1; end
      else if (b && c) begin nf.src = 3'd1; nf.pw = 1'b1; end
      else if (s)      begin nf.src = 3'd0; nf.pw = 1'b1; end
    end
    exp_f = nf;
  endtask

  task automatic cyc(input logic s, b, c, jj, jr, r, e, input logic [1:0] cause, input string tag);
    bus.seq_req = s;  bus.br_req = b;  bus.br_cond = c; bus.j_req = jj;
    bus.jr_req  = jr; bus.rte_req = r; bus.exc_req = e; bus.exc_cause = cause;
    model(s, b, c, jj, jr, r, e, cause);
    @(posedge clk);
    #1;
    bus.seq_req = 0; bus.br_req = 0; bus.br_cond = 0; bus.j_req = 0;
    bus.jr_req  = 0; bus.rte_req = 0; bus.exc_req = 0; bus.exc_cause = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'd0, tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge.
  task automatic reset_mid(input string tag);
    reset_n = 1'b0;
    q.delete();
    exp_f = '0;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bus.seq_req = 0; bus.br_req = 0; bus.br_cond = 0; bus.j_req = 0;
    bus.jr_req  = 0; bus.rte_req = 0; bus.exc_req = 0; bus.exc_cause = 0;
    exp_f = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;
    idle("idle0");

    //  s  b  c  j  jr r  e  cause
    cyc(0, 1, 1, 1, 0, 0, 0, 2'd0, "j_over_br");
    idle("j_over_br_post");
    cyc(1, 1, 0, 0, 0, 0, 0, 2'd0, "brnt_seq");
    idle("brnt_seq_post");
    cyc(0, 1, 0, 0, 0, 0, 0, 2'd0, "brnt_alone");
    cyc(0, 1, 1, 0, 0, 0, 0, 2'd0, "br_taken");

    cyc(0, 0, 0, 0, 0, 0, 1, 2'd1, "exc1_epc");
    idle("exc1_rd1");
    cyc(0, 0, 0, 0, 1, 0, 0, 2'd0, "exc1_rd2_jr");
    idle("exc1_ld");
    idle("exc1_done");
    cyc(0, 0, 0, 0, 0, 1, 0, 2'd0, "rte");
    idle("rte_post");

    cyc(0, 0, 0, 0, 0, 0, 1, 2'd3, "exc3_epc");
    idle("exc3_rd1");
    reset_mid("rst_in_rd");
    idle("post_rst1");
    idle("post_rst2");
    idle("post_rst3");

    cyc(1, 0, 0, 0, 0, 0, 1, 2'd2, "exc_seq");
    for (int i = 0; i < 5; i++) idle("exc_seq_tail");

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_mid("rnd_rst");
      end else begin
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 6) == 0, 2'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
